// File: rtl/keypad_scan_matrix.sv
// Column-scanned keypad matrix with a two-flop row synchroniser, per-frame
// key classification and a frame-rate press/release debouncer.
module keypad_scan_matrix #(
   parameter int NUM_COLS        = 3,
   parameter int NUM_ROWS        = 4,
   parameter int SCAN_DIV        = 4,
   parameter int DEBOUNCE_FRAMES = 3,
   parameter int CODE_W          = $clog2(NUM_ROWS*NUM_COLS)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                scan_en,
   input  logic [NUM_ROWS-1:0] key_row,
   output logic [NUM_COLS-1:0] key_col,
   output logic [CODE_W-1:0]   key_code,
   output logic                key_valid,
   output logic                key_release,
   output logic                key_held,
   output logic                key_multi
);

   localparam int DIV_W = $clog2(SCAN_DIV);
   localparam int COL_W = $clog2(NUM_COLS);
   localparam logic [DIV_W-1:0] DWELL_LAST = DIV_W'(SCAN_DIV-1);
   localparam logic [COL_W-1:0] COL_LAST   = COL_W'(NUM_COLS-1);
   localparam logic [3:0]       DB_TARGET  = 4'(DEBOUNCE_FRAMES);

   typedef enum logic [1:0] {IDLE, PRESS_DB, HELD, REL_DB} state_t;

   logic [NUM_ROWS-1:0] row_meta_p0;
   logic [NUM_ROWS-1:0] row_sync_p1;
   logic                active;
   logic [DIV_W-1:0]    dwell;
   logic [COL_W-1:0]    col_idx;
   logic [1:0]          acc_hits;
   logic [CODE_W-1:0]   acc_code;
   logic [3:0]          col_pop;
   logic [CODE_W-1:0]   col_code;
   logic [1:0]          frame_hits;
   logic [CODE_W-1:0]   frame_code;
   state_t              state;
   logic [3:0]          cnt;
   logic [CODE_W-1:0]   cand;

   // Hit count saturates at 2: the frame only needs none / one / many.
   function automatic logic [1:0] sat_hits(input logic [1:0] acc, input logic [3:0] pop);
      logic [4:0] sum;
      sum = {3'b000, acc} + {1'b0, pop};
      return (sum >= 5'd2) ? 2'd2 : sum[1:0];
   endfunction

   // Stage p0/p1: row synchroniser
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         row_meta_p0 <= '0;
         row_sync_p1 <= '0;
      end else begin
         row_meta_p0 <= key_row;
         row_sync_p1 <= row_meta_p0;
      end
   end

   always_comb begin
      col_pop  = '0;
      col_code = '0;
      for (int r = 0; r < NUM_ROWS; r++) begin
         if (row_sync_p1[r]) begin
            col_pop  = col_pop + 4'd1;
            col_code = CODE_W'(r*NUM_COLS) + CODE_W'(col_idx);
         end
      end
      frame_hits = sat_hits(acc_hits, col_pop);
      frame_code = (acc_hits == 2'd0) ? col_code : acc_code;
   end

   // Scan sequencing, frame accumulation and debounce FSM
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         active      <= 1'b0;
         dwell       <= '0;
         col_idx     <= '0;
         acc_hits    <= '0;
         acc_code    <= '0;
         key_col     <= '0;
         state       <= IDLE;
         cnt         <= '0;
         cand        <= '0;
         key_code    <= '0;
         key_valid   <= 1'b0;
         key_release <= 1'b0;
         key_held    <= 1'b0;
         key_multi   <= 1'b0;
      end else begin
         key_valid   <= 1'b0;
         key_release <= 1'b0;
         if (!scan_en) begin
            active   <= 1'b0;
            dwell    <= '0;
            col_idx  <= '0;
            acc_hits <= '0;
            acc_code <= '0;
            key_col  <= '0;
            state    <= IDLE;
            cnt      <= '0;
            key_held <= 1'b0;
         end else if (!active) begin
            active   <= 1'b1;
            dwell    <= '0;
            col_idx  <= '0;
            acc_hits <= '0;
            acc_code <= '0;
            key_col  <= NUM_COLS'(1);
         end else if (dwell != DWELL_LAST) begin
            dwell <= dwell + 1'b1;
         end else begin
            dwell <= '0;
            if (col_idx != COL_LAST) begin
               col_idx  <= col_idx + 1'b1;
               key_col  <= key_col << 1;
               acc_hits <= frame_hits;
               acc_code <= frame_code;
            end else begin
               // Frame end: last column folded in, classify and debounce.
               col_idx   <= '0;
               key_col   <= NUM_COLS'(1);
               acc_hits  <= '0;
               acc_code  <= '0;
               key_multi <= (frame_hits == 2'd2);
               case (state)
                  IDLE: begin
                     if (frame_hits == 2'd1) begin
                        cand <= frame_code;
                        if (DB_TARGET == 4'd1) begin
                           key_code  <= frame_code;
                           key_valid <= 1'b1;
                           key_held  <= 1'b1;
                           state     <= HELD;
                        end else begin
                           cnt   <= 4'd1;
                           state <= PRESS_DB;
                        end
                     end
                  end
                  PRESS_DB: begin
                     if (frame_hits == 2'd1 && frame_code == cand) begin
                        if (cnt + 4'd1 == DB_TARGET) begin
                           key_code  <= cand;
                           key_valid <= 1'b1;
                           key_held  <= 1'b1;
                           cnt       <= '0;
                           state     <= HELD;
                        end else begin
                           cnt <= cnt + 4'd1;
                        end
                     end else begin
                        cnt   <= '0;
                        state <= IDLE;
                     end
                  end
                  HELD: begin
                     if (frame_hits == 2'd0) begin
                        if (DB_TARGET == 4'd1) begin
                           key_release <= 1'b1;
                           key_held    <= 1'b0;
                           state       <= IDLE;
                        end else begin
                           cnt   <= 4'd1;
                           state <= REL_DB;
                        end
                     end
                  end
                  REL_DB: begin
                     if (frame_hits == 2'd0) begin
                        if (cnt + 4'd1 == DB_TARGET) begin
                           key_release <= 1'b1;
                           key_held    <= 1'b0;
                           cnt         <= '0;
                           state       <= IDLE;
                        end else begin
                           cnt <= cnt + 4'd1;
                        end
                     end else begin
                        cnt   <= '0;
                        state <= HELD;
                     end
                  end
                  default: state <= IDLE;
               endcase
            end
         end
      end
   end

endmodule

// File: tb/tb_keypad_scan_matrix.sv
// Randomised bench for keypad_scan_matrix: a keypad model drives the rows and
// a frame-level reference predicts every output each cycle.
module tb_keypad_scan_matrix;

   localparam int NC    = 3;
   localparam int NR    = 4;
   localparam int SD    = 4;
   localparam int DB    = 3;
   localparam int CW    = $clog2(NR*NC);
   localparam int FRAME = NC*SD;

   logic          clk = 1'b0;
   logic          rst;
   logic          scan_en;
   logic [NR-1:0] key_row;
   logic [NC-1:0] key_col;
   logic [CW-1:0] key_code;
   logic          key_valid;
   logic          key_release;
   logic          key_held;
   logic          key_multi;

   keypad_scan_matrix #(
      .NUM_COLS(NC), .NUM_ROWS(NR), .SCAN_DIV(SD), .DEBOUNCE_FRAMES(DB), .CODE_W(CW)
   ) dut (
      .clk(clk), .rst(rst), .scan_en(scan_en), .key_row(key_row), .key_col(key_col),
      .key_code(key_code), .key_valid(key_valid), .key_release(key_release),
      .key_held(key_held), .key_multi(key_multi)
   );

   always #5 clk = ~clk;

   bit [NC-1:0] pressed [NR];

   // Switch matrix: a row reads high when a pressed key sits on a driven column.
   always_comb begin
      key_row = '0;
      for (int r = 0; r < NR; r++) key_row[r] = |(pressed[r] & key_col);
   end

   int vectors, miscompares;
   int n, cand, press_run, none_run, m_code, valid_seen, rel_seen;
   bit active, m_held, m_valid, m_rel, m_multi;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      vectors++;
      if (obs !== exp_v) begin
         miscompares++;
         $display("FAIL %s: got %0d, want %0d at %0t", tag, obs, exp_v, $time);
      end
   endtask

   task automatic model_reset();
      active = 0; n = 0; cand = 0; press_run = 0; none_run = 0; m_code = 0;
      m_held = 0; m_valid = 0; m_rel = 0; m_multi = 0;
   endtask

   // -1 = no key, -2 = several keys, otherwise the single key code.
   function automatic int classify();
      int hits, code;
      hits = 0; code = 0;
      for (int r = 0; r < NR; r++)
         for (int c = 0; c < NC; c++)
            if (pressed[r][c]) begin hits++; code = r*NC + c; end
      if (hits == 0) return -1;
      if (hits > 1) return -2;
      return code;
   endfunction

   task automatic frame_result(input int res);
      m_multi = (res == -2);
      if (!m_held) begin
         if (res >= 0 && press_run > 0 && res == cand) press_run++;
         else if (res >= 0 && press_run == 0) begin cand = res; press_run = 1; end
         else press_run = 0;
         if (press_run == DB) begin
            m_held = 1; m_code = cand; m_valid = 1; press_run = 0;
         end
      end else begin
         if (res == -1) none_run++; else none_run = 0;
         if (none_run == DB) begin m_held = 0; m_rel = 1; none_run = 0; end
      end
   endtask

   task automatic check_outputs(input string tag);
      chk({tag, "_col"}, 32'(key_col), active ? 32'(1 << ((n/SD)%NC)) : 32'd0);
      chk({tag, "_valid"}, 32'(key_valid), 32'(m_valid));
      chk({tag, "_release"}, 32'(key_release), 32'(m_rel));
      chk({tag, "_held"}, 32'(key_held), 32'(m_held));
      chk({tag, "_multi"}, 32'(key_multi), 32'(m_multi));
      chk({tag, "_code"}, 32'(key_code), 32'(m_code));
   endtask

   task automatic tick();
      @(posedge clk);
      m_valid = 0; m_rel = 0;
      if (!scan_en) begin
         active = 0; n = 0; m_held = 0; press_run = 0; none_run = 0;
      end else if (!active) begin
         active = 1; n = 0;
      end else begin
         if (n % FRAME == FRAME-1) frame_result(classify());
         n++;
      end
      #1;
      if (key_valid === 1'b1) valid_seen++;
      if (key_release === 1'b1) rel_seen++;
      check_outputs("cyc");
   endtask

   task automatic run(input int cycles);
      repeat (cycles) tick();
   endtask

   task automatic sync_frame();
      for (int i = 0; i < 2*FRAME && !(active && n % FRAME == 0); i++) tick();
      chk("frame_align", 32'(active && n % FRAME == 0), 32'd1);
   endtask

   task automatic hold(input int a, input int b, input int frames);
      sync_frame();
      for (int r = 0; r < NR; r++) pressed[r] = '0;
      if (a >= 0) pressed[a/NC][a%NC] = 1'b1;
      if (b >= 0) pressed[b/NC][b%NC] = 1'b1;
      run(frames*FRAME);
   endtask

   task automatic apply_reset(input int cycles);
      rst = 1'b1;
      #1;
      model_reset();
      check_outputs("rst_assert");
      repeat (cycles) @(posedge clk);
      #1;
      check_outputs("rst_hold");
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      int kind, sel, a, b, last;
      vectors = 0; miscompares = 0; valid_seen = 0; rel_seen = 0; last = 4;
      for (int r = 0; r < NR; r++) pressed[r] = '0;
      scan_en = 1'b1;
      apply_reset(2);

      // Idle scan: columns walk 001, 010, 100 for SD cycles each.
      hold(-1, -1, 2);
      chk("idle_no_valid", 32'(valid_seen), 32'd0);

      // Steady press at row 1, column 1.
      valid_seen = 0;
      hold(4, -1, 5);
      chk("press_pulses", 32'(valid_seen), 32'd1);
      chk("press_code", 32'(key_code), 32'd4);
      chk("press_held", 32'(key_held), 32'd1);

      // Second key while held.
      hold(4, 7, 2);
      chk("held_multi", 32'(key_multi), 32'd1);
      chk("held_multi_code", 32'(key_code), 32'd4);
      chk("held_multi_held", 32'(key_held), 32'd1);

      // Short release gap, then a full release.
      rel_seen = 0;
      hold(-1, -1, 2);
      hold(4, -1, 1);
      chk("gap_no_release", 32'(rel_seen), 32'd0);
      hold(-1, -1, 3);
      chk("release_pulses", 32'(rel_seen), 32'd1);
      chk("release_held", 32'(key_held), 32'd0);
      chk("release_code", 32'(key_code), 32'd4);

      // Bounce 2 on / 1 off / 2 on.
      valid_seen = 0;
      hold(4, -1, 2);
      hold(-1, -1, 1);
      hold(4, -1, 2);
      hold(-1, -1, 1);
      chk("bounce_no_valid", 32'(valid_seen), 32'd0);

      // Two keys from idle.
      hold(0, 8, 3);
      chk("idle_multi", 32'(key_multi), 32'd1);
      chk("idle_multi_no_valid", 32'(valid_seen), 32'd0);

      // scan_en drop while held.
      rel_seen = 0;
      hold(4, -1, 4);
      run(5);
      scan_en = 1'b0;
      tick();
      chk("disable_col", 32'(key_col), 32'd0);
      chk("disable_held", 32'(key_held), 32'd0);
      run(3);
      chk("disable_no_release", 32'(rel_seen), 32'd0);
      scan_en = 1'b1;

      // Reset in the middle of press debounce.
      valid_seen = 0;
      hold(4, -1, 2);
      run(5);
      apply_reset(2);
      chk("rst_abort_no_valid", 32'(valid_seen), 32'd0);
      hold(-1, -1, 1);

      for (int i = 0; i < 80; i++) begin
         kind = $urandom_range(0, 9);
         if (kind == 0) begin
            run($urandom_range(1, FRAME-1));
            scan_en = 1'b0;
            run($urandom_range(1, 4));
            scan_en = 1'b1;
         end else if (kind == 1) begin
            run($urandom_range(0, FRAME-1));
            apply_reset($urandom_range(1, 3));
         end else begin
            sel = $urandom_range(0, 5);
            a = ($urandom_range(0, 1) == 1) ? last : $urandom_range(0, NR*NC-1);
            b = -1;
            if (sel == 0) a = -1;
            else if (sel == 1) begin
               b = $urandom_range(0, NR*NC-1);
               if (b == a) b = (a + 1) % (NR*NC);
            end else last = a;
            hold(a, b, $urandom_range(1, 4));
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/keypad_scan_matrix.md
KEYPAD_SCAN_MATRIX -- requirements
Module: keypad_scan_matrix

Parameters
REQ-001 The block SHALL take these parameters, one per line: name, default, meaning.
  NUM_COLS  3  scanned columns, 2..8.
  NUM_ROWS  4  sensed rows, 2..8.
  SCAN_DIV  4  clock cycles each column is driven, >=3.
  DEBOUNCE_FRAMES  3  consecutive identical frames needed to accept a press or a release, 1..15.
  CODE_W  clog2(NUM_ROWS*NUM_COLS)  key code width (derived).

Interface
REQ-002 The block SHALL have these ports, one per line: name  direction  width  meaning.
  clk  in  1  single clock; every register is clocked on its rising edge.
  rst  in  1  asynchronous, active-high reset.
  scan_en  in  1  enables scanning; low parks the block.
  key_row  in  NUM_ROWS  active-high row sense, asynchronous to clk.
  key_col  out  NUM_COLS  one-hot active-high column drive.
  key_code  out  CODE_W  code of the last accepted key, row_idx*NUM_COLS + col_idx.
  key_valid  out  1  one-cycle pulse when a press is accepted.
  key_release  out  1  one-cycle pulse when a release is accepted.
  key_held  out  1  level, high while an accepted key is held.
  key_multi  out  1  level, high while the most recent frame saw more than one key.

Function
REQ-003 key_row SHALL pass through a 2-flop synchroniser before use.
REQ-004 A dwell counter SHALL count 0..SCAN_DIV-1.
REQ-005 A column index SHALL advance 0..NUM_COLS-1 when the dwell counter wraps, then wrap back to 0.
REQ-006 key_col SHALL equal one-hot(col_idx) while enabled, otherwise all zeros.
REQ-007 The synchronised rows SHALL be sampled on the last dwell cycle of each column.
REQ-008 One pass over all columns SHALL form a frame of NUM_COLS*SCAN_DIV cycles.
REQ-009 Each frame result SHALL be NONE (no bits), SINGLE(code) (exactly one bit set in the whole frame) or MULTI (two or more bits, in one column or across columns).
REQ-010 The debounce FSM SHALL have states IDLE, PRESS_DB, HELD and REL_DB, and SHALL update only at a frame end.
REQ-011 In IDLE, SINGLE(c) SHALL load candidate=c and count=1, then go to PRESS_DB; if DEBOUNCE_FRAMES=1 it SHALL accept immediately and go to HELD.
REQ-012 In PRESS_DB, SINGLE(candidate) SHALL increment count; when count reaches DEBOUNCE_FRAMES the press SHALL be accepted and the FSM SHALL go to HELD.
REQ-013 In PRESS_DB, NONE, MULTI or a different code SHALL return the FSM to IDLE with no output.
REQ-014 On press accept, key_code SHALL load candidate, key_valid SHALL be high for exactly the next cycle, and key_held SHALL be set.
REQ-015 In HELD, NONE SHALL go to REL_DB with count=1; SINGLE or MULTI SHALL stay in HELD; key_code SHALL NOT change.
REQ-016 In REL_DB, NONE SHALL increment count; at DEBOUNCE_FRAMES the FSM SHALL pulse key_release for one cycle, clear key_held and go to IDLE; any non-NONE frame SHALL return to HELD.
REQ-017 key_code SHALL hold its value after release until the next accepted press.
REQ-018 key_multi SHALL update at every frame end and SHALL NOT block accepting a key.
REQ-019 When scan_en falls, on the next edge the dwell counter, column index, frame accumulator and FSM SHALL reset to 0/IDLE, and key_col and key_held SHALL go to 0; key_release SHALL NOT pulse and key_code SHALL hold.
REQ-020 When scan_en rises, column 0 SHALL be driven from the next cycle; a partial frame SHALL never be evaluated.
REQ-021 key_valid and key_release SHALL never be high in the same cycle.

Reset
REQ-022 While rst is high, all of the following SHALL be held: key_col=0, key_code=0, key_valid=0, key_release=0, key_held=0, key_multi=0, FSM=IDLE, all counters=0, synchroniser=0.
REQ-023 Asserting rst mid-operation SHALL abort all debounce progress with no pulse.
REQ-024 After rst releases with scan_en=1, the first edge SHALL drive column 0 (key_col=001).

Verification (defaults: 3 columns, 4 rows, SCAN_DIV=4, DEBOUNCE_FRAMES=3, 12-cycle frame)
REQ-025 Reset/scan: rst pulse, then scan_en=1 -> key_col=000 during reset, then 001 for 4 cycles, 010 for 4, 100 for 4, repeating; all other outputs 0.
REQ-026 Press: key at row 1, column 1 held steady -> exactly one key_valid pulse with key_code=4 after the third complete matching frame; key_held=1 from then on.
REQ-027 Bounce: key present for 2 frames, absent for 1, present for 2 -> no key_valid; key_held stays 0.
REQ-028 Multi: keys at codes 0 and 8 pressed together from IDLE -> key_multi=1 and no key_valid; in HELD with code 4, adding code 7 -> key_multi=1, key_held stays 1, key_code stays 4.
REQ-029 Release: from HELD with code 4, three NONE frames -> one key_release pulse, key_held=0, key_code stays 4; a 2-NONE-frame gap instead -> no release.
REQ-030 Abort: scan_en low during HELD -> key_col=0 and key_held=0 on the next edge with no key_release; rst asserted during PRESS_DB -> no key_valid, and all outputs at their reset values.
